// File: rtl/alu_rr_arbiter.sv
// Round-robin front end for one shared 4-bit combinational ALU.
// NUM_REQ requesters each offer (opcode, A, B). One request is granted at a time.
// The chosen operands are registered onto the alu_* outputs for one execute cycle.
// The ALU result is then captured and returned on a single response channel,
// tagged with the owning requester's index.
//
// Handshake semantics (request and response channels alike): a transfer happens
// on a rising edge where valid and ready are both high. A producer that raises
// valid keeps it and its payload stable until the transfer. ready may depend
// combinationally on valid (the request grant does). valid never depends on ready.
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [2*NUM_REQ-1:0] req_opcode,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic [1:0]           alu_opcode,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    input  logic [3:0]           alu_y,
    input  logic                 alu_flag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [3:0]           rsp_y,
    output logic                 rsp_flag,
    output logic                 busy,
    output logic [CNT_W-1:0]     ops_done,
    output logic [1:0]           dbg_state,
    output logic [ID_W-1:0]      dbg_rr_ptr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]       alu_opcode_q, alu_opcode_d;
    logic [3:0]       alu_a_q, alu_a_d;
    logic [3:0]       alu_b_q, alu_b_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [3:0]       rsp_y_q, rsp_y_d;
    logic             rsp_flag_q, rsp_flag_d;
    logic [CNT_W-1:0] ops_done_q, ops_done_d;

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;

    // Index p+k folded back into 0..NUM_REQ-1 (k never exceeds NUM_REQ).
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return ID_W'(s);
    endfunction

    // Grant search: the first valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[wrap_add(rr_ptr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(rr_ptr_q, k);
            end
        end
    end

    // One-hot ready towards the granted requester, only while idle.
    // Suppressed during reset so that reset wins over a same-cycle handshake.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && grant_found && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state and datapath updates for IDLE -> EXEC -> RESP -> IDLE.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_id_d     = rsp_id_q;
        rsp_y_d      = rsp_y_q;
        rsp_flag_d   = rsp_flag_q;
        ops_done_d   = ops_done_q;
        case (state_q)
            ST_IDLE: begin
                // A found grant is always accepted: ready goes straight to that requester.
                if (grant_found) begin
                    alu_opcode_d = req_opcode[{grant_idx, 1'b0} +: 2];
                    alu_a_d      = req_a[{grant_idx, 2'b00} +: 4];
                    alu_b_d      = req_b[{grant_idx, 2'b00} +: 4];
                    rsp_id_d     = grant_idx;
                    rr_ptr_d     = wrap_add(grant_idx, 1);
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // The ALU has had a full cycle on registered operands; sample it.
                rsp_y_d    = alu_y;
                rsp_flag_d = alu_flag;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    ops_done_d = ops_done_q + CNT_W'(1);
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_id_q     <= '0;
            rsp_y_q      <= '0;
            rsp_flag_q   <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_id_q     <= rsp_id_d;
            rsp_y_q      <= rsp_y_d;
            rsp_flag_q   <= rsp_flag_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_y      = rsp_y_q;
    assign rsp_flag   = rsp_flag_q;
    assign busy       = (state_q != ST_IDLE);
    assign ops_done   = ops_done_q;
    assign dbg_state  = state_q;
    assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: the shared ALU is modelled in the bench. A second
// instance with CNT_W=2 runs in lockstep on the same inputs to exercise
// counter wrap. Responses are checked against a queue of expected results.
module tb_alu_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [2*NUM_REQ-1:0] req_opcode;
    logic [4*NUM_REQ-1:0] req_a;
    logic [4*NUM_REQ-1:0] req_b;
    logic [1:0]           alu_opcode;
    logic [3:0]           alu_a, alu_b, alu_y;
    logic                 alu_flag;
    logic                 rsp_valid, rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [3:0]           rsp_y;
    logic                 rsp_flag, busy;
    logic [CNT_W-1:0]     ops_done;
    logic [1:0]           dbg_state;
    logic [ID_W-1:0]      dbg_rr_ptr;

    logic [NUM_REQ-1:0]   w2_req_ready;
    logic [1:0]           w2_alu_opcode;
    logic [3:0]           w2_alu_a, w2_alu_b, w2_alu_y;
    logic                 w2_alu_flag, w2_rsp_valid, w2_rsp_flag, w2_busy;
    logic [ID_W-1:0]      w2_rsp_id, w2_dbg_rr_ptr;
    logic [3:0]           w2_rsp_y;
    logic [1:0]           w2_ops_done, w2_dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [ID_W+4:0] exp_q[$];

    alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_flag(rsp_flag), .busy(busy), .ops_done(ops_done),
        .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
    );

    alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(w2_req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .alu_opcode(w2_alu_opcode), .alu_a(w2_alu_a), .alu_b(w2_alu_b),
        .alu_y(w2_alu_y), .alu_flag(w2_alu_flag),
        .rsp_valid(w2_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(w2_rsp_id),
        .rsp_y(w2_rsp_y), .rsp_flag(w2_rsp_flag), .busy(w2_busy), .ops_done(w2_ops_done),
        .dbg_state(w2_dbg_state), .dbg_rr_ptr(w2_dbg_rr_ptr)
    );

    // Reference behaviour of the team ALU: returns {flag, y}.
    function automatic logic [4:0] alu_model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {(a > b) ? 1'b0 : 1'b1, a - b};
            2'b10:   return (a > b) ? 5'b01111 : 5'b10000;
            default: return {((a & b) != 4'd0) ? 1'b0 : 1'b1, a & b};
        endcase
    endfunction

    always_comb {alu_flag, alu_y} = alu_model(alu_opcode, alu_a, alu_b);
    always_comb {w2_alu_flag, w2_alu_y} = alu_model(w2_alu_opcode, w2_alu_a, w2_alu_b);

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back({ID_W'(i), alu_model(req_opcode[2*i +: 2], req_a[4*i +: 4], req_b[4*i +: 4])});
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_rsp: got id=%0d y=%b flag=%b, expected no response", rsp_id, rsp_y, rsp_flag);
                end else begin
                    logic [ID_W+4:0] e;
                    e = exp_q.pop_front();
                    if ({rsp_id, rsp_flag, rsp_y} !== e) begin
                        failures++;
                        $display("FAIL sb_rsp: got id=%0d flag=%b y=%b, expected id=%0d flag=%b y=%b",
                                 rsp_id, rsp_flag, rsp_y, e[ID_W+4:5], e[4], e[3:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_payload(input int i, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        req_opcode[2*i +: 2] = op;
        req_a[4*i +: 4]      = a;
        req_b[4*i +: 4]      = b;
    endtask

    // Raise requester i, hold until granted, then drop; returns in the EXEC cycle.
    task automatic issue(input int i, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        bit got;
        got = 1'b0;
        tick();
        set_payload(i, op, a, b);
        req_valid[i] = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        tick();
        req_valid[i] = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: requester %0d got no grant within 20 cycles, expected a grant", i);
        end
    endtask

    // Wait for a response handshake; returns just after the accepting edge.
    task automatic wait_rsp(output logic [ID_W-1:0] id, output logic [3:0] y, output logic f);
        bit got;
        got = 1'b0;
        id = '0; y = '0; f = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                got = 1'b1;
                id = rsp_id; y = rsp_y; f = rsp_flag;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout: no response within 40 cycles, expected one");
        end
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        req_opcode = '0; req_a = '0; req_b = '0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, busy, dbg_state} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: ready=%b rsp_valid=%b busy=%b state=%0d, expected all 0", req_ready, rsp_valid, busy, dbg_state);
        end
        checks++;
        if ({rsp_id, rsp_y, rsp_flag} !== '0) begin
            failures++;
            $display("FAIL reset_rsp: id=%0d y=%b flag=%b, expected 0", rsp_id, rsp_y, rsp_flag);
        end
        checks++;
        if ({alu_opcode, alu_a, alu_b} !== '0) begin
            failures++;
            $display("FAIL reset_alu: op=%b a=%h b=%h, expected 0", alu_opcode, alu_a, alu_b);
        end
        checks++;
        if (ops_done !== '0 || dbg_rr_ptr !== '0) begin
            failures++;
            $display("FAIL reset_cnt: ops_done=%0d rr_ptr=%0d, expected 0 and 0", ops_done, dbg_rr_ptr);
        end
    endtask

    task automatic test_single();
        tick();
        rsp_ready = 1'b1;
        set_payload(0, 2'b00, 4'd9, 4'd8);
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant: req_ready=%b, expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || {alu_opcode, alu_a, alu_b} !== {2'b00, 4'd9, 4'd8}) begin
            failures++;
            $display("FAIL single_exec: rsp_valid=%b busy=%b op=%b a=%0d b=%0d, expected 0 1 00 9 8",
                     rsp_valid, busy, alu_opcode, alu_a, alu_b);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_y, rsp_flag} !== {1'b1, 2'd0, 4'b0001, 1'b1}) begin
            failures++;
            $display("FAIL single_rsp: valid=%b id=%0d y=%b flag=%b, expected 1 0 0001 1", rsp_valid, rsp_id, rsp_y, rsp_flag);
        end
        tick();
        @(negedge clk);
        checks++;
        if (ops_done !== 16'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done: ops_done=%0d busy=%b, expected 1 0", ops_done, busy);
        end
    endtask

    task automatic test_opcodes();
        logic [1:0] top [3];
        logic [3:0] ta [3];
        logic [3:0] tb [3];
        logic [3:0] ey [3];
        logic       ef [3];
        logic [ID_W-1:0] id;
        logic [3:0] y;
        logic f;
        top = '{2'b01, 2'b10, 2'b11};
        ta  = '{4'd3, 4'd7, 4'hC};
        tb  = '{4'd5, 4'd2, 4'd3};
        ey  = '{4'b1110, 4'b1111, 4'b0000};
        ef  = '{1'b1, 1'b0, 1'b1};
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            issue(2, top[k], ta[k], tb[k]);
            wait_rsp(id, y, f);
            checks++;
            if ({id, y, f} !== {2'd2, ey[k], ef[k]}) begin
                failures++;
                $display("FAIL opcode_%b: id=%0d y=%b flag=%b, expected id=2 y=%b flag=%b", top[k], id, y, f, ey[k], ef[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        int order [6];
        int at [6];
        int ng, g, multi;
        logic [ID_W-1:0] id;
        logic [3:0] y;
        logic f;
        ng = 0; multi = 0;
        tick();
        rst = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            set_payload(i, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        req_valid = '1;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 40 && ng < 6; cyc++) begin
            @(negedge clk);
            if ($countones(req_ready) > 1) multi++;
            g = -1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && req_valid[i]) g = i;
            end
            if (g >= 0) begin
                order[ng] = g;
                at[ng] = cyc;
                ng++;
            end
            tick();
            if (g >= 0) begin
                set_payload(g, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
            if (ng == 6) req_valid = '0;
        end
        req_valid = '0;
        checks++;
        if (ng != 6) begin
            failures++;
            $display("FAIL rr_count: saw %0d grants, expected 6", ng);
        end
        for (int k = 0; k < ng; k++) begin
            checks++;
            if (order[k] != k % NUM_REQ) begin
                failures++;
                $display("FAIL rr_order: grant %0d went to %0d, expected %0d", k, order[k], k % NUM_REQ);
            end
            if (k > 0) begin
                checks++;
                if (at[k] - at[k-1] != 3) begin
                    failures++;
                    $display("FAIL rr_spacing: grant %0d came %0d cycles after previous, expected 3", k, at[k] - at[k-1]);
                end
            end
        end
        checks++;
        if (multi != 0) begin
            failures++;
            $display("FAIL rr_onehot: %0d cycles with several ready bits, expected 0", multi);
        end
        wait_rsp(id, y, f);
    endtask

    task automatic test_backpressure();
        logic [ID_W-1:0] id0;
        logic [3:0] y0;
        logic f0;
        logic [ID_W-1:0] id;
        logic [3:0] y;
        logic f;
        rsp_ready = 1'b0;
        issue(1, 2'b00, 4'd15, 4'd15);
        set_payload(3, 2'b01, 4'd4, 4'd9);
        req_valid[3] = 1'b1;
        @(negedge clk);
        id0 = 2'd1; y0 = 4'b1110; f0 = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, busy, req_ready, rsp_id, rsp_y, rsp_flag} !== {1'b1, 1'b1, 4'b0000, id0, y0, f0}) begin
                failures++;
                $display("FAIL bp_hold_%0d: valid=%b busy=%b ready=%b id=%0d y=%b flag=%b, expected 1 1 0000 %0d %b %b",
                         s, rsp_valid, busy, req_ready, rsp_id, rsp_y, rsp_flag, id0, y0, f0);
            end
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL bp_next_grant: req_ready=%b, expected 1000", req_ready);
        end
        tick();
        req_valid[3] = 1'b0;
        wait_rsp(id, y, f);
    endtask

    task automatic test_reset_mid();
        logic [ID_W-1:0] id;
        logic [3:0] y;
        logic f;
        rsp_ready = 1'b1;
        issue(1, 2'b11, 4'd6, 4'd3);
        wait_rsp(id, y, f);
        issue(2, 2'b11, 4'd15, 4'd15);
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            set_payload(i, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        req_valid = '1;
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_during: ready=%b rsp_valid=%b, expected 0000 0", req_ready, rsp_valid);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, busy, dbg_state, rsp_id, rsp_y, rsp_flag, alu_opcode, alu_a, alu_b, ops_done, dbg_rr_ptr} !== '0) begin
            failures++;
            $display("FAIL rstmid_state: valid=%b busy=%b state=%0d id=%0d y=%b flag=%b op=%b a=%h b=%h done=%0d ptr=%0d, expected all 0",
                     rsp_valid, busy, dbg_state, rsp_id, rsp_y, rsp_flag, alu_opcode, alu_a, alu_b, ops_done, dbg_rr_ptr);
        end
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rstmid_grant: req_ready=%b, expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        wait_rsp(id, y, f);
        checks++;
        if (id !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_rsp_id: id=%0d, expected 0", id);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp2 [5];
        logic [ID_W-1:0] id;
        logic [3:0] y;
        logic f;
        exp2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rsp_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            issue(k % NUM_REQ, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            wait_rsp(id, y, f);
            @(negedge clk);
            checks++;
            if (w2_ops_done !== exp2[k] || ops_done !== CNT_W'(k + 1)) begin
                failures++;
                $display("FAIL wrap_%0d: ops_done(CNT_W=2)=%0d ops_done=%0d, expected %0d %0d", k, w2_ops_done, ops_done, exp2[k], k + 1);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_opcodes();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d expected responses never arrived, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one instance of the team's 4-bit, 2-bit-opcode combinational ALU among NUM_REQ independent requesters.
- Each requester issues an operation (opcode, A, B) over a valid/ready handshake.
- The block grants requesters in round-robin order, drives the shared ALU from registered operands, captures y/flag, and returns the result on a single response channel tagged with the requester ID.
- It sits between requesting sequencers and the ALU instance; the ALU itself is external and connected through the alu_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must satisfy 2**ID_W >= NUM_REQ.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_opcode  input  2*NUM_REQ  packed opcodes; requester i uses bits [2i+1:2i].
- req_a  input  4*NUM_REQ  packed A operands; requester i uses bits [4i+3:4i].
- req_b  input  4*NUM_REQ  packed B operands, same packing as req_a.
- alu_opcode  output  2  opcode to the shared ALU.
- alu_a  output  4  A operand to the shared ALU.
- alu_b  output  4  B operand to the shared ALU.
- alu_y  input  4  ALU result.
- alu_flag  input  1  ALU flag.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_y  output  4  captured ALU result.
- rsp_flag  output  1  captured ALU flag.
- busy  output  1  high whenever the state is not IDLE.
- ops_done  output  CNT_W  count of completed responses; wraps modulo 2**CNT_W.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_flag=0, alu_opcode=0, alu_a=0, alu_b=0, busy=0, ops_done=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant selection:
  - The grant is combinational: the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[grant]=1; all other req_ready bits are 0.
  - If no req_valid bit is set, all req_ready bits are 0 and the state stays IDLE.
- IDLE, accept (req_valid[g] & req_ready[g]):
  - Latch opcode/A/B of requester g into the alu_* output registers.
  - Latch rsp_id=g.
  - Set rr_ptr=(g+1) mod NUM_REQ.
  - Go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_* outputs hold the latched operands; req_ready is all 0.
  - At the end of the cycle capture rsp_y<=alu_y and rsp_flag<=alu_flag, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_y and rsp_flag are stable.
  - On rsp_ready=1: rsp_valid<=0, ops_done<=ops_done+1, go to IDLE.
  - While rsp_ready=0: hold all outputs and block new grants.
- Latency: accept at cycle T -> rsp_valid at T+2. Throughput is one operation per 3 cycles with rsp_ready tied high.
- alu_* outputs keep the last latched values in IDLE and RESP; they change only on accept.
- The arbiter does not interpret the opcode. Expected ALU results, for checking:
  - 00: {flag,y} = A+B, 5-bit result.
  - 01: y = A-B mod 16; flag = 0 if A>B, else 1.
  - 10: y=1111, flag=0 if A>B; otherwise y=0000, flag=1.
  - 11: y = A&B; flag = 0 if A&B is nonzero, else 1.
- Boundary rules:
  - Requester protocol: req_valid and its payload hold until accepted. If req_valid drops before accept, no state changes.
  - Simultaneous requests: exactly one grant per accept; rr_ptr guarantees every requester is served within NUM_REQ grants.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - ops_done wraps from 2**CNT_W-1 to 0 without a flag.
  - rst in any state: the in-flight transaction is discarded, no response is issued, and all registers return to their reset values on the next edge. rst has priority over any handshake in the same cycle.
  - A new request asserted during EXEC/RESP waits; there is no grant until the state is IDLE.

Test Plan:
- Single request, req0 opcode=00 A=9 B=8, rsp_ready=1 -> req_ready[0] same cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_y=0001, rsp_flag=1; ops_done=1.
- Opcode coverage on req2 (ALU model attached):
  - 01 A=3 B=5 -> y=1110, flag=1.
  - 10 A=7 B=2 -> y=1111, flag=0.
  - 11 A=C B=3 -> y=0000, flag=1.
  - All responses return with rsp_id=2.
- Round robin: all 4 req_valid held high from reset, rsp_ready=1 -> grant order 0,1,2,3,0,1; accepts spaced exactly 3 cycles apart; never two req_ready bits high.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_id/y/flag stable, req_ready all 0, busy=1; after rsp_ready=1, the next grant comes one cycle later.
- Reset mid-operation: assert rst during EXEC -> no rsp_valid; next cycle all outputs are at reset values, rr_ptr=0, and requester 0 wins the next arbitration.
- Wrap: CNT_W=2, perform 5 operations -> ops_done sequence 1,2,3,0,1.
